// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer between the UART receiver core and the bus register block.
// Captures each byte once per rdy assertion, acknowledges it, and tracks a sticky overflow.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_rdy,
    input  logic [WIDTH-1:0]      i_rx_data,
    output logic                  o_rx_done,
    input  logic                  i_rd,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_clr_ovf
);

    // state | meaning
    // IDLE  | ready to capture the next byte when i_rx_rdy rises
    // WAIT  | byte taken; hold off until the receiver drops i_rx_rdy
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];

    logic capture;
    logic pop;
    logic push;
    logic drop;

    assign o_empty    = (count_q == '0);
    assign o_full     = (count_q == DEPTH_C);
    assign o_count    = count_q;
    assign o_rx_done  = done_q;
    assign o_overflow = ovf_q;
    assign o_data     = mem_q[rptr_q];

    assign pop = i_rd && !o_empty;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_rx_rdy) begin
                    capture = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!i_rx_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign push = capture && (!o_full || pop);
    assign drop = capture && !push;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        done_d  = capture;
        ovf_d   = ovf_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst && push) begin
            mem_q[wptr_q] <= i_rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue scoreboard of accepted bytes.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rd;
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       ovf;
    logic       clr_ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb[$];
    logic       m_ovf;

    uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_rdy   (rx_rdy),
        .i_rx_data  (rx_data),
        .o_rx_done  (rx_done),
        .i_rd       (rd),
        .o_data     (data),
        .o_empty    (empty),
        .o_full     (full),
        .o_count    (count),
        .o_overflow (ovf),
        .i_clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, " count"}, 32'(count), 32'(sb.size()));
        check({tag, " empty"}, 32'(empty), 32'(sb.size() == 0));
        check({tag, " full"}, 32'(full), 32'(sb.size() == 16));
        check({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    // Receiver offers a byte, keeps rdy high for hold extra cycles after done, then drops it.
    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_rdy  = 1'b1;
        rx_data = b;
        if (sb.size() < 16) sb.push_back(b);
        else m_ovf = 1'b1;
        @(negedge clk);
        check("done pulse", 32'(rx_done), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("done held", 32'(rx_done), 32'd0);
            check("hold count", 32'(count), 32'(sb.size()));
        end
        rx_rdy = 1'b0;
        @(negedge clk);
        check("done after", 32'(rx_done), 32'd0);
    endtask

    task automatic pop_one();
        logic [7:0] exp;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("pop data", 32'(data), 32'(exp));
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        rd      = 1'b0;
        clr_ovf = 1'b0;
        m_ovf   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_status("reset");
        check("reset done", 32'(rx_done), 32'd0);

        // single byte
        send_byte(8'h5A, 0);
        check_status("single");
        check("single data", 32'(data), 32'h5A);
        pop_one();
        check_status("single popped");

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        check_status("filled");
        send_byte(8'hAA, 0);
        check_status("overflowed");
        while (sb.size() > 0) pop_one();
        check_status("drained");
        clr_ovf = 1'b1;
        m_ovf   = 1'b0;
        @(negedge clk);
        clr_ovf = 1'b0;
        check_status("ovf cleared");

        // full FIFO, capture coincident with pop
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 0);
        check_status("refilled");
        rx_rdy  = 1'b1;
        rx_data = 8'h77;
        check("simul head", 32'(data), 32'(sb.pop_front()));
        sb.push_back(8'h77);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("simul done", 32'(rx_done), 32'd1);
        check_status("simul");
        rx_rdy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 15; i++) pop_one();
        check("wrap tail", 32'(data), 32'h77);
        pop_one();
        check_status("wrap drained");

        // receiver late to drop rdy, then pop on empty
        send_byte(8'h3C, 5);
        check_status("late rdy");
        pop_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check_status("pop empty");

        // overflow clear, and drop racing a clear
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 0);
        send_byte(8'hBB, 0);
        check_status("ovf set");
        clr_ovf = 1'b1;
        m_ovf   = 1'b0;
        @(negedge clk);
        clr_ovf = 1'b0;
        check_status("ovf clr");
        rx_rdy  = 1'b1;
        rx_data = 8'hCC;
        clr_ovf = 1'b1;
        m_ovf   = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("race done", 32'(rx_done), 32'd1);
        check_status("race set wins");
        rx_rdy = 1'b0;
        @(negedge clk);

        // reset with entries stored
        for (int i = 0; i < 11; i++) pop_one();
        check_status("five left");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        m_ovf = 1'b0;
        check_status("mid reset");
        check("mid reset done", 32'(rx_done), 32'd0);

        send_byte(8'h99, 0);
        check_status("post reset");
        pop_one();
        check_status("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
